// File: rtl/lm75a_poll_ctrl.sv
// Purpose : autonomous I2C master sweeping NUM_SENSORS LM75A sensors (address BASE_ADDR+ch), reading each 2-byte temp register.
// Latency : 29 SCL bit times per channel; upd pulses 1 clk after STOP; sweeps start every POLL_MS (or back-to-back if overrun).
// Backpr. : none; no clock stretching; enable low lets the running channel finish (with upd), then the bus idles.
// Ports   : clk, rst_n (async, active low), enable | scl (push-pull), sda (open drain) | temp[11*ch+:11], valid, nack,
//           upd/upd_ch completion strobe.
module lm75a_poll_ctrl #(
    parameter int         CLK_HZ      = 50_000_000,
    parameter int         SCL_HZ      = 250_000,
    parameter int         NUM_SENSORS = 2,
    parameter logic [6:0] BASE_ADDR   = 7'h48,
    parameter int         POLL_MS     = 100
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    output logic                     scl,
    inout  wire                      sda,
    output logic [11*NUM_SENSORS-1:0] temp,
    output logic [NUM_SENSORS-1:0]   valid,
    output logic [NUM_SENSORS-1:0]   nack,
    output logic                     upd,
    output logic [2:0]               upd_ch
);
    localparam int             QTR       = CLK_HZ / (4 * SCL_HZ);
    localparam int             QW        = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [QW-1:0]  QTR_M1    = QW'(QTR - 1);
    localparam int             POLL_CLKS = (CLK_HZ / 1000) * POLL_MS;
    localparam int             PW        = $clog2(POLL_CLKS + 1);
    localparam logic [PW-1:0]  POLL_M1   = PW'(POLL_CLKS - 1);
    localparam logic [2:0]     LAST_CH   = 3'(NUM_SENSORS - 1);

    typedef enum logic [3:0] {
        S_RECOVER, S_IDLE, S_START, S_ADDR, S_AACK, S_RMSB,
        S_MACK, S_RLSB, S_MNACK, S_STOP, S_NEXT
    } state_t;

    state_t                   state_q, state_d;
    logic [QW-1:0]            qcnt_q, qcnt_d;
    logic [1:0]               phase_q, phase_d;
    logic [3:0]               bit_q, bit_d;
    logic [2:0]               ch_q, ch_d;
    logic [PW-1:0]            poll_q, poll_d;
    logic                     rec_q, rec_d;     // STOP belongs to bus recovery, not a read
    logic                     err_q, err_d;     // current channel was NACKed
    logic                     samp_q, samp_d;
    logic [10:0]              sh_q, sh_d;       // {MSB, LSB[7:5]}
    logic [11*NUM_SENSORS-1:0] temp_q, temp_d;
    logic [NUM_SENSORS-1:0]   valid_q, valid_d, nack_q, nack_d;
    logic                     scl_q, scl_d, sda_low_q, sda_low_d;
    logic                     sda_meta_q, sda_sync_q;
    logic                     bit_end;
    logic [7:0]               addr_byte;

    assign sda    = sda_low_q ? 1'b0 : 1'bz;
    assign scl    = scl_q;
    assign temp   = temp_q;
    assign valid  = valid_q;
    assign nack   = nack_q;
    assign upd    = (state_q == S_NEXT);
    assign upd_ch = ch_q;

    always_comb begin
        state_d = state_q;  qcnt_d = qcnt_q;   phase_d = phase_q;  bit_d = bit_q;
        ch_d    = ch_q;     poll_d = poll_q;   rec_d   = rec_q;    err_d = err_q;
        samp_d  = samp_q;   sh_d   = sh_q;     temp_d  = temp_q;
        valid_d = valid_q;  nack_d = nack_q;   bit_end = 1'b0;

        if (poll_q != '0) poll_d = poll_q - 1'b1;

        // Quarter-bit sequencer; IDLE and NEXT sit at phase 0 and do not advance it.
        if (state_q != S_IDLE && state_q != S_NEXT) begin
            if (qcnt_q == QTR_M1) begin
                qcnt_d  = '0;
                phase_d = phase_q + 2'd1;
                bit_end = (phase_q == 2'd3);
                if (phase_q == 2'd2) begin
                    // Entering phase 3: bus sample point. Only the top 3 LSB bits matter.
                    samp_d = sda_sync_q;
                    if (state_q == S_RMSB || (state_q == S_RLSB && bit_q < 4'd3))
                        sh_d = {sh_q[9:0], sda_sync_q};
                end
            end else begin
                qcnt_d = qcnt_q + 1'b1;
            end
        end

        case (state_q)
            S_RECOVER: if (bit_end && bit_q == 4'd8) state_d = S_STOP;
            S_IDLE: if (enable && poll_q == '0) begin
                state_d = S_START;
                poll_d  = POLL_M1;
            end
            S_START: if (bit_end) state_d = S_ADDR;
            S_ADDR:  if (bit_end && bit_q == 4'd7) state_d = S_AACK;
            S_AACK: if (bit_end) begin
                state_d = samp_q ? S_STOP : S_RMSB;
                err_d   = samp_q;
                for (int i = 0; i < NUM_SENSORS; i++) begin
                    if (ch_q == 3'(i)) begin
                        nack_d[i] = samp_q;
                        if (samp_q) valid_d[i] = 1'b0;
                    end
                end
            end
            S_RMSB:  if (bit_end && bit_q == 4'd7) state_d = S_MACK;
            S_MACK:  if (bit_end) state_d = S_RLSB;
            S_RLSB:  if (bit_end && bit_q == 4'd7) state_d = S_MNACK;
            S_MNACK: if (bit_end) state_d = S_STOP;
            S_STOP: if (bit_end) begin
                rec_d   = 1'b0;
                state_d = rec_q ? S_IDLE : S_NEXT;
                if (!rec_q && !err_q) begin
                    for (int i = 0; i < NUM_SENSORS; i++) begin
                        if (ch_q == 3'(i)) begin
                            temp_d[11*i +: 11] = sh_q;
                            valid_d[i]         = 1'b1;
                        end
                    end
                end
            end
            S_NEXT: begin
                err_d = 1'b0;
                if (enable && ch_q != LAST_CH) begin
                    ch_d    = ch_q + 3'd1;
                    state_d = S_START;
                end else begin
                    ch_d    = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_RECOVER;
        endcase

        if (bit_end) bit_d = (state_d == state_q) ? bit_q + 4'd1 : 4'd0;
    end

    // Bus levels are registered from the next-state view so they line up with state_q/phase_q.
    always_comb begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
        addr_byte = {BASE_ADDR + {4'b0, ch_q}, 1'b1};
        case (state_d)
            S_IDLE, S_START, S_NEXT: scl_d = 1'b1;
            default:                 scl_d = phase_d[1];
        endcase
        case (state_d)
            S_START: sda_low_d = phase_d[1];                  // fall while SCL high
            S_ADDR:  sda_low_d = ~addr_byte[3'd7 - bit_d[2:0]];
            S_MACK:  sda_low_d = 1'b1;
            S_STOP:  sda_low_d = (phase_d != 2'd3);           // rise while SCL high
            default: sda_low_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RECOVER; qcnt_q <= '0;  phase_q <= '0;  bit_q <= '0;
            ch_q    <= '0;        poll_q <= '0;  rec_q   <= 1'b1; err_q <= 1'b0;
            samp_q  <= 1'b1;      sh_q   <= '0;  temp_q  <= '0;
            valid_q <= '0;        nack_q <= '0;
            scl_q   <= 1'b1;      sda_low_q <= 1'b0;
            sda_meta_q <= 1'b1;   sda_sync_q <= 1'b1;
        end else begin
            state_q <= state_d;   qcnt_q <= qcnt_d; phase_q <= phase_d; bit_q <= bit_d;
            ch_q    <= ch_d;      poll_q <= poll_d; rec_q   <= rec_d;   err_q <= err_d;
            samp_q  <= samp_d;    sh_q   <= sh_d;   temp_q  <= temp_d;
            valid_q <= valid_d;   nack_q <= nack_d;
            scl_q   <= scl_d;     sda_low_q <= sda_low_d;
            // SDA is asynchronous to clk; the sample point sits well inside SCL high.
            sda_meta_q <= sda;    sda_sync_q <= sda_meta_q;
        end
    end
endmodule

// File: tb/tb_lm75a_poll_ctrl.sv
module tb_lm75a_poll_ctrl;
    localparam int NS = 2;

    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic scl, upd;
    logic [2:0] upd_ch;
    logic [11*NS-1:0] temp;
    logic [NS-1:0] valid, nack;
    wire  sda_bus;
    logic drv = 1'b0;

    assign sda_bus = drv ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    lm75a_poll_ctrl #(.CLK_HZ(4_000_000), .SCL_HZ(250_000), .NUM_SENSORS(NS),
                      .BASE_ADDR(7'h48), .POLL_MS(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .scl(scl), .sda(sda_bus),
        .temp(temp), .valid(valid), .nack(nack), .upd(upd), .upd_ch(upd_ch));

    typedef struct packed {
        logic [2:0]  ch;
        logic [7:0]  addr;
        logic        nk;
        logic        vl;
        logic [10:0] t;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] c, input logic [7:0] a, input logic n,
                                input logic v, input logic [10:0] t);
        exp_t e;
        e.ch = c; e.addr = a; e.nk = n; e.vl = v; e.t = t;
        return e;
    endfunction

    // Sensor model: responds to address 0x48+ch (read) when present[ch].
    logic       present [NS];
    logic [7:0] msb [NS];
    logic [7:0] lsb [NS];
    logic       p_scl = 1'b1, p_sda = 1'b1, in_xfer = 1'b0, started = 1'b0, sel_ok = 1'b0;
    logic [7:0] sh = '0, last_addr = '0;
    int         k = 0, sel_ch = 0, nstop = 0, rec_hi = 0, rec_lo = 0, rec_stop = 0, k_at_stop = 0;

    always @(negedge clk) begin : slave
        logic s_scl, s_sda;
        s_scl = scl;
        s_sda = sda_bus;
        if (!rst_n) begin
            in_xfer = 1'b0; drv = 1'b0; k = 0; nstop = 0; started = 1'b0;
            rec_hi = 0; rec_lo = 0;
        end else begin
            if (p_scl && s_scl && p_sda && !s_sda) begin
                in_xfer = 1'b1; k = 0;
                if (!started) begin started = 1'b1; rec_stop = nstop; end
            end else if (p_scl && s_scl && !p_sda && s_sda) begin
                if (in_xfer) k_at_stop = k;
                in_xfer = 1'b0; drv = 1'b0; nstop++;
            end
            if (!p_scl && s_scl) begin
                if (!started) begin
                    if (s_sda) rec_hi++; else rec_lo++;
                end
                if (in_xfer) begin
                    k++;
                    if (k <= 8) sh = {sh[6:0], s_sda};
                    if (k == 8) begin
                        last_addr = sh;
                        sel_ch    = int'(sh[7:1]) - 'h48;
                        sel_ok    = sh[0] && sel_ch >= 0 && sel_ch < NS && present[sel_ch];
                    end
                end
            end
            if (p_scl && !s_scl && in_xfer) begin
                drv = 1'b0;
                if (sel_ok) begin
                    if (k == 8)                  drv = 1'b1;
                    else if (k >= 9 && k <= 16)  drv = !msb[sel_ch][16-k];
                    else if (k >= 18 && k <= 25) drv = !lsb[sel_ch][25-k];
                end
            end
        end
        p_scl = s_scl;
        p_sda = s_sda;
    end

    // Monitor: every upd pops one expected completion.
    logic prev_upd = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        logic [11*NS-1:0] tv;
        logic [NS-1:0] nv, vv;
        if (rst_n && upd) begin
            chk("upd_single_clk", prev_upd, 0);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_upd: got upd_ch=%0d expected no update", upd_ch);
            end else begin
                e  = sb_q.pop_front();
                tv = temp >> (11 * e.ch);
                nv = nack >> e.ch;
                vv = valid >> e.ch;
                chk("upd_ch", upd_ch, e.ch);
                chk("addr_byte", last_addr, e.addr);
                chk("nack_bit", nv[0], e.nk);
                chk("valid_bit", vv[0], e.vl);
                chk("temp_ch", tv[10:0], e.t);
            end
        end
        prev_upd = rst_n && upd;
    end

    task automatic drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 12000) begin
            @(negedge clk);
            n++;
        end
        chk(name, sb_q.size(), 0);
    endtask

    task automatic wait_k(input string name, input int kk);
        int n = 0;
        while (!(in_xfer && k >= kk) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < 6000), 1);
    endtask

    initial begin
        int bad;
        present = '{1'b1, 1'b1};
        msb     = '{8'h19, 8'hE7};
        lsb     = '{8'h60, 8'h00};
        enable  = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_scl", scl, 1);
        chk("rst_sda", sda_bus, 1);
        chk("rst_temp", temp, 0);
        chk("rst_valid", valid, 0);
        chk("rst_nack", nack, 0);
        chk("rst_upd", upd, 0);
        chk("rst_upd_ch", upd_ch, 0);

        // Sweep 1: both sensors answer.
        sb_q.push_back(mk(3'd0, 8'h91, 1'b0, 1'b1, 11'h0CB));
        sb_q.push_back(mk(3'd1, 8'h93, 1'b0, 1'b1, 11'h738));
        rst_n = 1'b1;
        drain("sweep1_drain");
        // Recovery: 9 pulses with SDA high, plus the STOP's SCL rise with SDA low, one STOP.
        chk("rec_pulses_sda_hi", rec_hi, 9);
        chk("rec_pulses_sda_lo", rec_lo, 1);
        chk("rec_stop_before_start", rec_stop, 1);
        chk("sweep1_valid", valid, 2'b11);
        chk("sweep1_nack", nack, 2'b00);

        // Sweep 2: sensor 1 absent.
        present[1] = 1'b0;
        msb[0] = 8'h00; lsb[0] = 8'h20;
        sb_q.push_back(mk(3'd0, 8'h91, 1'b0, 1'b1, 11'h001));
        sb_q.push_back(mk(3'd1, 8'h93, 1'b1, 1'b0, 11'h738));
        drain("sweep2_drain");
        // 9 bits then the STOP's own SCL rise.
        chk("nack_stop_clock", k_at_stop, 10);
        chk("sweep2_valid", valid, 2'b01);
        chk("sweep2_nack", nack, 2'b10);

        // Sweep 3: enable dropped during RMSB of channel 0.
        present[1] = 1'b1;
        msb[0] = 8'h7D; lsb[0] = 8'h00;
        sb_q.push_back(mk(3'd0, 8'h91, 1'b0, 1'b1, 11'h3E8));
        wait_k("reach_rmsb", 12);
        enable = 1'b0;
        drain("sweep3_drain");
        bad = 0;
        repeat (6000) begin
            @(negedge clk);
            if (scl !== 1'b1 || sda_bus !== 1'b1) bad++;
        end
        chk("idle_bus_after_disable", bad, 0);
        chk("sweep3_nack", nack, 2'b10);

        // Sweep 4: reset during RLSB (LSB 0xFF keeps the sensor off the bus there).
        msb[0] = 8'h12; lsb[0] = 8'hFF;
        msb[1] = 8'hFF; lsb[1] = 8'hE0;
        enable = 1'b1;
        wait_k("reach_rlsb", 21);
        rst_n = 1'b0;
        #1;
        chk("midrst_scl", scl, 1);
        chk("midrst_sda", sda_bus, 1);
        chk("midrst_valid", valid, 0);
        chk("midrst_nack", nack, 0);
        chk("midrst_temp", temp, 0);
        chk("midrst_upd", upd, 0);
        repeat (5) @(negedge clk);
        sb_q.push_back(mk(3'd0, 8'h91, 1'b0, 1'b1, 11'h097));
        sb_q.push_back(mk(3'd1, 8'h93, 1'b0, 1'b1, 11'h7FF));
        rst_n = 1'b1;
        drain("sweep4_drain");
        chk("rec2_pulses_sda_hi", rec_hi, 9);
        chk("rec2_stop_before_start", rec_stop, 1);
        chk("sweep4_valid", valid, 2'b11);
        chk("sweep4_nack", nack, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
